// File: rtl/alu_sel_scheduler_pkg.sv
// Shared types and constants for the ALU result-mux scheduler.
// Imported by the arbiter and the scheduler top.
package alu_sel_pkg;

    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_A = 2'd0;
    localparam logic [SEL_W-1:0] SEL_B = 2'd1;
    localparam logic [SEL_W-1:0] SEL_C = 2'd2;
    localparam logic [SEL_W-1:0] SEL_D = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RESP
    } state_e;

endpackage

// File: rtl/alu_sel_scheduler_rr_arb4.sv
// Four-way round-robin arbiter, purely combinational.
// The search starts at ptr_i and wraps modulo four.
module rr_arb4
    import alu_sel_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_oh_o,
    output logic [SEL_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [SEL_W-1:0] idx;

    // First active requester at or after the pointer wins
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = ptr_i + SEL_W'(i);
            if (!any_o && req_i[idx]) begin
                any_o          = 1'b1;
                gnt_idx_o      = idx;
                gnt_oh_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sel_scheduler.sv
// Time-shares the ALU result mux between four requesters: grant,
// hold the select for SETTLE cycles, capture z, return it over valid/ready.
module alu_sel_scheduler
    import alu_sel_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [2*NREQ-1:0]  op,
    output logic [NREQ-1:0]    gnt,
    output logic [SEL_W-1:0]   alu_ctrl,
    input  logic [WIDTH-1:0]   alu_z,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [SEL_W-1:0]   rsp_id,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               busy
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);

    state_e             state_q;
    logic [SEL_W-1:0]   ptr_q;
    logic [3:0]         cnt_q;
    logic [SEL_W-1:0]   alu_ctrl_q;
    logic               rsp_valid_q;
    logic [SEL_W-1:0]   rsp_id_q;
    logic [WIDTH-1:0]   rsp_data_q;

    logic [NREQ-1:0]    arb_oh;
    logic [SEL_W-1:0]   arb_idx;
    logic               arb_any;
    logic [SEL_W-1:0]   win_sel;

    rr_arb4 u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (arb_oh),
        .gnt_idx_o (arb_idx),
        .any_o     (arb_any)
    );

    // Select value requested by the current winner
    always_comb begin
        win_sel = op[{arb_idx, 1'b0} +: SEL_W];
    end

    // Grant only leaves the block in IDLE and never while reset is held
    always_comb begin
        gnt  = (rst_n && state_q == IDLE) ? arb_oh : '0;
        busy = (state_q != IDLE);
    end

    // Transaction FSM with the select, counter and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            alu_ctrl_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        alu_ctrl_q <= win_sel;
                        rsp_id_q   <= arb_idx;
                        ptr_q      <= arb_idx + 2'd1;
                        cnt_q      <= CNT_INIT;
                        state_q    <= alu_sel_pkg::SETTLE;
                    end
                end
                alu_sel_pkg::SETTLE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        rsp_data_q  <= alu_z;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign alu_ctrl  = alu_ctrl_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule
